// File: rtl/p4fpga_sched_pkg.sv
// p4fpga_sched_pkg: shared FSM encodings and FIFO read latency for drain schedulers
package p4fpga_sched_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
  localparam int DISTRAM_FIFO_RD_LATENCY = 2;
endpackage

// File: rtl/distram_fifo_rr_drain_rr_pick.sv
// rr_pick: first set request bit at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic [W:0] sel;
  assign dbl = {req, req};
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = 2*N-1; k >= 0; k--)
      if (dbl[k] && k >= int'(ptr)) begin
        found = 1'b1;
        sel = (W+1)'(k);
      end
    idx = W'(sel >= (W+1)'(N) ? sel - (W+1)'(N) : sel);
  end
endmodule

// File: rtl/distram_fifo_rr_drain.sv
// distram_fifo_rr_drain: round-robin burst drain of NUM_QUEUES FIFOs into one tagged output stream
module distram_fifo_rr_drain
  import p4fpga_sched_pkg::*;
#(
  parameter int NUM_QUEUES = 4,
  parameter int DATA_WIDTH = 64,
  parameter int QID_BITS   = 2,
  parameter int RD_LATENCY = DISTRAM_FIFO_RD_LATENCY,
  parameter int MAX_BURST  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES-1:0]            fifo_empty,
  input  logic [NUM_QUEUES-1:0]            fifo_valid,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_QUEUES-1:0]            fifo_re,
  input  logic                             out_almostfull,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [QID_BITS-1:0]              out_qid,
  output logic                             err
);
  localparam int MW = $clog2(RD_LATENCY+1);
  state_t state, state_n;
  logic [QID_BITS-1:0] rr_ptr, rr_ptr_n, cur_q, cur_q_n, pick_idx, issue_q, tq;
  logic [7:0] burst_cnt, burst_cnt_n;
  logic pick_found, issue, can_cont, bad;
  logic [RD_LATENCY-1:0] tag_v;
  logic [QID_BITS-1:0] tag_q [RD_LATENCY];
  logic [MW-1:0] mask_cnt;
  logic [NUM_QUEUES-1:0] tq_hot;
  rr_pick #(.N(NUM_QUEUES), .W(QID_BITS)) u_pick (
    .req(~fifo_empty),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  assign can_cont = !fifo_empty[cur_q] && !out_almostfull && burst_cnt < 8'(MAX_BURST);
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    cur_q_n = cur_q;
    burst_cnt_n = burst_cnt;
    issue = 1'b0;
    issue_q = cur_q;
    if (state == ST_IDLE) begin
      if (pick_found && !out_almostfull) begin
        issue = 1'b1;
        issue_q = pick_idx;
        cur_q_n = pick_idx;
        burst_cnt_n = 8'd1;
        state_n = ST_BURST;
      end
    end else if (can_cont) begin
      issue = 1'b1;
      burst_cnt_n = burst_cnt + 8'd1;
    end else begin
      state_n = ST_IDLE;
      rr_ptr_n = cur_q == QID_BITS'(NUM_QUEUES-1) ? '0 : cur_q + 1'b1;
    end
  end
  assign fifo_re = (issue && !reset) ? NUM_QUEUES'(1) << issue_q : '0;
  assign tq = tag_q[RD_LATENCY-1];
  assign tq_hot = NUM_QUEUES'(1) << tq;
  assign bad = tag_v[RD_LATENCY-1] ? (!fifo_valid[tq] || |(fifo_valid & ~tq_hot))
                                   : (|fifo_valid && mask_cnt == '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      rr_ptr <= '0;
      cur_q <= '0;
      burst_cnt <= '0;
      tag_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_qid <= '0;
      err <= 1'b0;
      mask_cnt <= MW'(RD_LATENCY);
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      cur_q <= cur_q_n;
      burst_cnt <= burst_cnt_n;
      tag_v <= {tag_v[RD_LATENCY-2:0], issue};
      tag_q[0] <= issue_q;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      out_valid <= tag_v[RD_LATENCY-1];
      if (tag_v[RD_LATENCY-1]) begin
        out_data <= fifo_dout[tq*DATA_WIDTH +: DATA_WIDTH];
        out_qid <= tq;
      end
      if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
      if (bad) err <= 1'b1;
    end
  end
endmodule
